// File: rtl/rob_multi_if.sv
// rob_multi_if: shared types and the dispatch/writeback/commit/recovery bus of the reorder buffer.
package rob_multi_pkg;
    localparam int ROB_SIZE = 16;
    localparam int ROB_W = $clog2(ROB_SIZE);
    localparam int PHYS_W = 6;
    localparam int EPOCH_W = 3;
    localparam int ARCH_W = 5;
    localparam int PC_W = 32;

    typedef enum logic [2:0] {
        UOP_ALU,
        UOP_BRANCH,
        UOP_JUMP,
        UOP_LOAD,
        UOP_STORE
    } uop_class_t;

    typedef struct packed {
        uop_class_t        uop_class;
        logic              uses_rd;
        logic [ARCH_W-1:0] rd_arch;
        logic [PC_W-1:0]   pc;
    } decoded_bundle_t;

    typedef struct packed {
        logic [ROB_W-1:0]   rob_idx;
        logic [EPOCH_W-1:0] epoch;
        logic               is_branch;
        logic               mispredict;
    } fu_wb_t;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               mispredict;
        logic [EPOCH_W-1:0] epoch;
        logic               is_branch;
        logic               is_load;
        logic               is_store;
        logic               uses_rd;
        logic [ARCH_W-1:0]  rd_arch;
        logic [PHYS_W-1:0]  pd_new;
        logic [PHYS_W-1:0]  pd_old;
        logic [PC_W-1:0]    pc;
    } rob_entry_t;
endpackage

interface rob_multi_if #(
    parameter int ALLOC_W   = 2,
    parameter int WB_W      = 2,
    parameter int COMMIT_W  = 2,
    parameter int RECOVER_W = 2,
    parameter int ROB_W_P   = rob_multi_pkg::ROB_W,
    parameter int PHYS_W_P  = rob_multi_pkg::PHYS_W
);
    import rob_multi_pkg::*;

    logic [ALLOC_W-1:0]                     alloc_valid;
    logic                                   alloc_ready;
    decoded_bundle_t [ALLOC_W-1:0]          alloc_bundle;
    logic [ALLOC_W-1:0][PHYS_W_P-1:0]       alloc_pd_new;
    logic [ALLOC_W-1:0][PHYS_W_P-1:0]       alloc_pd_old;
    logic [ALLOC_W-1:0][ROB_W_P-1:0]        alloc_rob_idx;
    logic [WB_W-1:0]                        wb_valid;
    fu_wb_t [WB_W-1:0]                      wb_pkt;
    logic                                   wb_ready;
    logic [COMMIT_W-1:0]                    commit_valid;
    logic                                   commit_ready;
    rob_entry_t [COMMIT_W-1:0]              commit_entry;
    logic [COMMIT_W-1:0][ROB_W_P-1:0]       commit_rob_idx;
    logic                                   flush_valid;
    logic                                   mispredict_fire;
    logic [RECOVER_W-1:0]                   recover_valid;
    rob_entry_t [RECOVER_W-1:0]             recover_entry;
    logic [RECOVER_W-1:0][ROB_W_P-1:0]      recover_rob_idx;
    logic [ROB_W_P:0]                       occupancy;
    logic [EPOCH_W-1:0]                     global_epoch;

    modport master (
        output alloc_valid, alloc_bundle, alloc_pd_new, alloc_pd_old,
        output wb_valid, wb_pkt, commit_ready, flush_valid,
        input  alloc_ready, alloc_rob_idx, wb_ready, commit_valid, commit_entry, commit_rob_idx,
        input  mispredict_fire, recover_valid, recover_entry, recover_rob_idx, occupancy, global_epoch
    );

    modport slave (
        input  alloc_valid, alloc_bundle, alloc_pd_new, alloc_pd_old,
        input  wb_valid, wb_pkt, commit_ready, flush_valid,
        output alloc_ready, alloc_rob_idx, wb_ready, commit_valid, commit_entry, commit_rob_idx,
        output mispredict_fire, recover_valid, recover_entry, recover_rob_idx, occupancy, global_epoch
    );
endinterface

// File: rtl/rob_multi.sv
// rob_multi: superscalar reorder buffer with in-order alloc/commit, out-of-order completion
// and epoch-tagged youngest-first walk-back on branch mispredict.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int ROB_SIZE_P = ROB_SIZE,
    parameter int ROB_W_P    = $clog2(ROB_SIZE_P),
    parameter int PHYS_W_P   = PHYS_W,
    parameter int ALLOC_W    = 2,
    parameter int WB_W       = 2,
    parameter int COMMIT_W   = 2,
    parameter int RECOVER_W  = 2
) (
    input logic     clk,
    input logic     rst,
    rob_multi_if.slave io
);
    typedef enum logic {NORMAL, RECOVERY} state_t;
    typedef logic [ROB_W_P-1:0] idx_t;
    typedef logic [ROB_W_P:0]   cnt_t;

    rob_entry_t                ent [ROB_SIZE_P];
    rob_entry_t [ALLOC_W-1:0]  new_ent;
    idx_t                      head, tail, tail_nx, rec_tgt, tgt, age, best_age;
    idx_t [WB_W-1:0]           wb_idx;
    cnt_t                      occ, n_alloc, n_commit, n_rec, rem;
    logic [EPOCH_W-1:0]        epoch;
    logic [WB_W-1:0]           hit, mp;
    logic                      recovering, found, blk;
    state_t                    state, state_nx;

    assign io.occupancy = occ;
    assign io.global_epoch = epoch;

    always_comb begin
        recovering = state == RECOVERY;
        io.alloc_ready = !rst && !recovering && occ <= cnt_t'(ROB_SIZE_P - ALLOC_W);
        io.wb_ready = !(recovering || io.flush_valid);
        n_alloc = '0;
        new_ent = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            io.alloc_rob_idx[i] = tail + idx_t'(i);
            new_ent[i].valid = 1'b1;
            new_ent[i].epoch = epoch;
            new_ent[i].is_branch = io.alloc_bundle[i].uop_class inside {UOP_BRANCH, UOP_JUMP};
            new_ent[i].is_load = io.alloc_bundle[i].uop_class == UOP_LOAD;
            new_ent[i].is_store = io.alloc_bundle[i].uop_class == UOP_STORE;
            new_ent[i].uses_rd = io.alloc_bundle[i].uses_rd;
            new_ent[i].rd_arch = io.alloc_bundle[i].rd_arch;
            new_ent[i].pd_new = PHYS_W'(io.alloc_pd_new[i][PHYS_W_P-1:0]);
            new_ent[i].pd_old = PHYS_W'(io.alloc_pd_old[i][PHYS_W_P-1:0]);
            new_ent[i].pc = io.alloc_bundle[i].pc;
            n_alloc = n_alloc + cnt_t'(io.alloc_ready && io.alloc_valid[i]);
        end
        // Completion only counts against a live entry of the same epoch; the oldest mispredict wins.
        hit = '0;
        mp = '0;
        found = 1'b0;
        age = '0;
        best_age = '0;
        tgt = head;
        for (int p = 0; p < WB_W; p++) begin
            wb_idx[p] = idx_t'(io.wb_pkt[p].rob_idx);
            hit[p] = io.wb_valid[p] && io.wb_ready && ent[wb_idx[p]].valid
                     && ent[wb_idx[p]].epoch == io.wb_pkt[p].epoch;
            mp[p] = hit[p] && io.wb_pkt[p].is_branch && io.wb_pkt[p].mispredict;
            age = wb_idx[p] - head;
            if (mp[p] && (!found || age < best_age)) begin
                found = 1'b1;
                best_age = age;
                tgt = wb_idx[p];
            end
        end
        io.mispredict_fire = |mp;
        // A store or a resolved mispredict closes the commit group after itself.
        blk = recovering;
        n_commit = '0;
        io.commit_valid = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            io.commit_rob_idx[k] = head + idx_t'(k);
            io.commit_entry[k] = ent[io.commit_rob_idx[k]];
            io.commit_valid[k] = !blk && io.commit_entry[k].valid
                                 && (io.commit_entry[k].done || io.commit_entry[k].is_store)
                                 && cnt_t'(k) < occ;
            blk = blk || !io.commit_valid[k] || io.commit_entry[k].is_store
                  || (io.commit_entry[k].done && io.commit_entry[k].mispredict);
            n_commit = n_commit + cnt_t'(io.commit_ready && io.commit_valid[k]);
        end
        rem = cnt_t'(idx_t'(tail - rec_tgt - idx_t'(1)));
        n_rec = '0;
        io.recover_valid = '0;
        for (int j = 0; j < RECOVER_W; j++) begin
            io.recover_rob_idx[j] = tail - idx_t'(j + 1);
            io.recover_entry[j] = ent[io.recover_rob_idx[j]];
            io.recover_valid[j] = recovering && cnt_t'(j) < rem;
            n_rec = n_rec + cnt_t'(io.recover_valid[j]);
        end
        tail_nx = tail + idx_t'(n_alloc) - idx_t'(n_rec);
        state_nx = recovering ? (tail_nx == rec_tgt + idx_t'(1) ? NORMAL : RECOVERY)
                              : (io.mispredict_fire && tail_nx != tgt + idx_t'(1) ? RECOVERY : NORMAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            head <= '0;
            tail <= '0;
            occ <= '0;
            epoch <= '0;
            rec_tgt <= '0;
            for (int i = 0; i < ROB_SIZE_P; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done <= 1'b0;
            end
        end else if (io.flush_valid) begin
            state <= NORMAL;
            head <= '0;
            tail <= '0;
            occ <= '0;
            epoch <= '0;
            rec_tgt <= '0;
            for (int i = 0; i < ROB_SIZE_P; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done <= 1'b0;
            end
        end else begin
            state <= state_nx;
            head <= head + idx_t'(n_commit);
            tail <= tail_nx;
            occ <= occ + n_alloc - n_commit - n_rec;
            if (io.mispredict_fire) begin
                epoch <= epoch + EPOCH_W'(1);
                rec_tgt <= tgt;
            end
            for (int i = 0; i < ALLOC_W; i++)
                if (io.alloc_ready && io.alloc_valid[i]) ent[io.alloc_rob_idx[i]] <= new_ent[i];
            for (int p = 0; p < WB_W; p++)
                if (hit[p]) begin
                    ent[wb_idx[p]].done <= 1'b1;
                    ent[wb_idx[p]].mispredict <= mp[p];
                end
            for (int k = 0; k < COMMIT_W; k++)
                if (io.commit_ready && io.commit_valid[k]) begin
                    ent[io.commit_rob_idx[k]].valid <= 1'b0;
                    ent[io.commit_rob_idx[k]].done <= 1'b0;
                end
            for (int j = 0; j < RECOVER_W; j++)
                if (io.recover_valid[j]) begin
                    ent[io.recover_rob_idx[j]].valid <= 1'b0;
                    ent[io.recover_rob_idx[j]].done <= 1'b0;
                end
        end
    end
endmodule
